color_mapper_pipe: RTL and testbench
====================================

# color_mapper_pipe

Parametrised, pipelined successor to the single-bit colour scrambler. It maps each of three CH_W-bit input colour channels onto any output channel, or forces an output channel to zero. Switch selections are committed only at frame boundaries, so a frame never tears. An optional auto-rotate mode cycles the channel permutation every ROT_FRAMES frames. The block sits between the pixel source and the VGA output stage and carries sync and valid through with matched latency.

## Interface
Parameters:
- CH_W, default 4: bits per colour channel.
- ROT_FRAMES, default 60: frames per auto-rotate step. Legal range 1..65535.
- FC_W, default 16: width of the frame counter. Must satisfy 2^FC_W ≥ ROT_FRAMES.

Ports:
- clk, in, 1: the single clock.
- rst_n, in, 1: reset. Synchronous and active-low.
- pix_r, pix_g, pix_b, in, CH_W each: input pixel channels.
- pix_valid, in, 1: input pixel qualifier.
- hsync_in, vsync_in, in, 1 each: syncs, passed through.
- frame_start, in, 1: one-cycle pulse aligned with the first pixel of a frame.
- sel_r, sel_g, sel_b, in, 2 each: source select for each output channel. 0 = R, 1 = G, 2 = B, 3 = zero.
- auto_rot, in, 1: enables automatic rotation.
- out_r, out_g, out_b, out, CH_W each: mapped pixel.
- out_valid, out, 1: delayed pix_valid.
- hsync_out, vsync_out, out, 1 each: delayed syncs.
- rot_state, out, 2: current rotation offset, range 0..2.

## Operation
- Shadow selects sel_*, and inv when CMAP_INVERT_EN is defined, are sampled every cycle.
- Active selects load from the shadow only on a cycle where frame_start=1.
- The pixel that accompanies frame_start is the first pixel mapped with the new selects.
- Effective select = 3 when the active select is 3; otherwise (active + rot_state) mod 3.
- Output channel = the chosen input channel, or all zeros when the effective select is 3.
- Frame counter fcnt (FC_W bits) and rot_state advance only when auto_rot=1 and frame_start=1:
  - if fcnt == ROT_FRAMES−1: fcnt ← 0 and rot_state ← (rot_state+1) mod 3 (2 wraps to 0);
  - otherwise fcnt ← fcnt+1.
- auto_rot=0: fcnt and rot_state are cleared to 0 on the next clock, so mapping reverts to the plain selects.
  - The clear is applied in the same cycle as any commit.
  - The rotation offset is never held mid-frame: rot_state changes only at a frame_start, or on the auto_rot clear.
- A rotation step and a select commit on the same frame_start both apply to that first pixel.
- Data, valid and syncs move through the pipeline unconditionally. There is no backpressure.
- Output data for cycles with pix_valid=0 is still mapped; downstream qualifies it with out_valid.

## Timing
- Latency is exactly 2 cycles from inputs to all outputs:
  - stage 1 registers the pixel, valid, syncs and frame_start;
  - stage 2 registers the mapped result.
- Throughput is one pixel per cycle.
- Reset, when rst_n=0 at a clk edge:
  - out_r/g/b = 0, out_valid = 0, hsync_out = vsync_out = 0;
  - rot_state = 0, fcnt = 0;
  - active selects = identity (R←0, G←1, B←2); inv = 0.
- The pipeline is flushed on reset, so the first valid output appears 2 cycles after the first valid input following rst_n=1.
- Reset asserted mid-frame discards in-flight pixels and returns the selects to identity until the next frame_start.
- Changes to sel_* mid-frame have no effect until the next frame_start.
- ROT_FRAMES=1: rot_state steps on every frame_start.

## Configuration
- CMAP_INVERT_EN defined:
  - adds input port inv, in, 3, with bits {r, g, b};
  - inv is committed with the selects at frame_start;
  - a set bit bitwise-inverts that output channel after mapping, so a zero select then yields all ones;
  - inv resets to 0.
- CMAP_INVERT_EN undefined: the inv port and its logic are absent, and behaviour is as above without inversion.

## Test plan
- Reset, then identity pass-through: pix = (3, 7, 12), pix_valid=1. Required: out = (3, 7, 12) and out_valid=1 two cycles later; all outputs were 0 during reset.
- Mid-frame select change: sel = (2, 0, 3) applied mid-frame. Required: output unchanged until frame_start. The frame_start pixel (3, 7, 12) maps to (12, 3, 0), exactly 2 cycles later.
- Auto-rotate with ROT_FRAMES=2, sel identity, auto_rot=1, 6 frame_starts. Required:
  - rot_state sequence 0, 0, 1, 1, 2, 2 at the frame starts, wrapping to 0 on the 6th step;
  - at rot_state=1, pixel (3, 7, 12) maps to (7, 12, 3).
- auto_rot dropped with rot_state=2. Required: rot_state=0 and fcnt=0 next cycle; output returns to the plain selects.
- Reset mid-frame with sel = (3, 3, 3) active. Required: flush and identity mapping; the outputs show no stale zero-mapped pixels.
- CMAP_INVERT_EN, CH_W=4, inv=3'b100, sel_r=3. Required: out_r=4'hF after the commit frame_start; other channels unchanged.

Source files
------------

// File: rtl/color_mapper_pipe.sv
// Two-stage colour channel router with frame-aligned select commit and optional auto-rotation.
// Define CMAP_INVERT_EN to add the per-channel output inversion port inv.
module color_mapper_pipe #(
  parameter int unsigned CH_W       = 4,
  parameter int unsigned ROT_FRAMES = 60,
  parameter int unsigned FC_W       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH_W-1:0] pix_r,
  input  logic [CH_W-1:0] pix_g,
  input  logic [CH_W-1:0] pix_b,
  input  logic            pix_valid,
  input  logic            hsync_in,
  input  logic            vsync_in,
  input  logic            frame_start,
  input  logic [1:0]      sel_r,
  input  logic [1:0]      sel_g,
  input  logic [1:0]      sel_b,
  input  logic            auto_rot,
`ifdef CMAP_INVERT_EN
  input  logic [2:0]      inv,
`endif
  output logic [CH_W-1:0] out_r,
  output logic [CH_W-1:0] out_g,
  output logic [CH_W-1:0] out_b,
  output logic            out_valid,
  output logic            hsync_out,
  output logic            vsync_out,
  output logic [1:0]      rot_state
);

  typedef enum logic [1:0] {
    SRC_R    = 2'd0,
    SRC_G    = 2'd1,
    SRC_B    = 2'd2,
    SRC_ZERO = 2'd3
  } src_e;

  localparam logic [FC_W-1:0] ROT_LAST = FC_W'(ROT_FRAMES - 1);

  logic [2:0] inv_in;
`ifdef CMAP_INVERT_EN
  assign inv_in = inv;
`else
  assign inv_in = '0;
`endif

  // Stage 1: pixel/control capture plus the shadow copy of the selects.
  logic [CH_W-1:0] s1_r, s1_g, s1_b;
  logic            s1_valid, s1_hs, s1_vs, s1_fs;
  src_e            shd_r, shd_g, shd_b;
  logic [2:0]      shd_inv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_valid <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_fs    <= 1'b0;
      shd_r    <= SRC_R;
      shd_g    <= SRC_G;
      shd_b    <= SRC_B;
      shd_inv  <= '0;
    end else begin
      s1_r     <= pix_r;
      s1_g     <= pix_g;
      s1_b     <= pix_b;
      s1_valid <= pix_valid;
      s1_hs    <= hsync_in;
      s1_vs    <= vsync_in;
      s1_fs    <= frame_start;
      shd_r    <= src_e'(sel_r);
      shd_g    <= src_e'(sel_g);
      shd_b    <= src_e'(sel_b);
      shd_inv  <= inv_in;
    end
  end

  // Rotation steps on the same edge that captures the frame_start pixel, so
  // that pixel is mapped in stage 2 with the new offset.
  logic [FC_W-1:0] fcnt;
  logic [1:0]      rot;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt <= '0;
      rot  <= '0;
    end else if (!auto_rot) begin
      fcnt <= '0;
      rot  <= '0;
    end else if (frame_start) begin
      if (fcnt == ROT_LAST) begin
        fcnt <= '0;
        rot  <= (rot == 2'd2) ? 2'd0 : rot + 2'd1;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign rot_state = rot;

  function automatic logic [CH_W-1:0] route(input src_e s, input logic [1:0] r_off,
                                            input logic [CH_W-1:0] r, input logic [CH_W-1:0] g,
                                            input logic [CH_W-1:0] b);
    logic [2:0] sum;
    logic [1:0] eff;
    sum = {1'b0, 2'(s)} + {1'b0, r_off};
    eff = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    if (s == SRC_ZERO) return '0;
    case (eff)
      2'd0:    return r;
      2'd1:    return g;
      default: return b;
    endcase
  endfunction

  // Stage 2: the frame_start pixel bypasses the active selects and uses the
  // shadow directly, while the shadow is committed into the active set.
  src_e       act_r, act_g, act_b;
  logic [2:0] act_inv;
  src_e       use_r, use_g, use_b;
  logic [2:0] use_inv;
  logic [CH_W-1:0] map_r, map_g, map_b;

  always_comb begin
    use_r   = act_r;
    use_g   = act_g;
    use_b   = act_b;
    use_inv = act_inv;
    if (s1_fs) begin
      use_r   = shd_r;
      use_g   = shd_g;
      use_b   = shd_b;
      use_inv = shd_inv;
    end
    map_r = route(use_r, rot, s1_r, s1_g, s1_b) ^ {CH_W{use_inv[2]}};
    map_g = route(use_g, rot, s1_r, s1_g, s1_b) ^ {CH_W{use_inv[1]}};
    map_b = route(use_b, rot, s1_r, s1_g, s1_b) ^ {CH_W{use_inv[0]}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_r     <= SRC_R;
      act_g     <= SRC_G;
      act_b     <= SRC_B;
      act_inv   <= '0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      act_r     <= use_r;
      act_g     <= use_g;
      act_b     <= use_b;
      act_inv   <= use_inv;
      out_r     <= map_r;
      out_g     <= map_g;
      out_b     <= map_b;
      out_valid <= s1_valid;
      hsync_out <= s1_hs;
      vsync_out <= s1_vs;
    end
  end

endmodule

// File: tb/tb_color_mapper_pipe.sv
// Randomised and directed bench for color_mapper_pipe against a cycle-level behavioural model.
module tb_color_mapper_pipe;
  localparam int CH_W = 4;
  localparam int ROT  = 2;
  localparam int OW   = 3 + 3 * CH_W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CH_W-1:0] pix_r = '0, pix_g = '0, pix_b = '0;
  logic            pix_valid = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, frame_start = 1'b0;
  logic [1:0]      sel_r = 2'd0, sel_g = 2'd1, sel_b = 2'd2;
  logic            auto_rot = 1'b0;
  logic [2:0]      inv_drv = '0;
  logic [CH_W-1:0] out_r, out_g, out_b;
  logic            out_valid, hsync_out, vsync_out;
  logic [1:0]      rot_state;

  int total = 0;
  int bad = 0;

  color_mapper_pipe #(.CH_W(CH_W), .ROT_FRAMES(ROT), .FC_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_valid(pix_valid), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .frame_start(frame_start),
    .sel_r(sel_r), .sel_g(sel_g), .sel_b(sel_b),
    .auto_rot(auto_rot),
`ifdef CMAP_INVERT_EN
    .inv(inv_drv),
`endif
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_valid(out_valid), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .rot_state(rot_state)
  );

  always #5 clk = ~clk;

  logic [OW-1:0] obs;
  assign obs = {out_valid, hsync_out, vsync_out, out_r, out_g, out_b};

  // Behavioural model state
  int            m_rot = 0;
  int            m_fcnt = 0;
  int            m_act[3] = '{0, 1, 2};
  logic [2:0]    m_inv = '0;
  logic [OW-1:0] pend = '0;
  logic [OW-1:0] exp_out = '0;

  function automatic logic [CH_W-1:0] mdl_ch(input int c);
    logic [CH_W-1:0] src[3];
    logic [CH_W-1:0] v;
    src[0] = pix_r; src[1] = pix_g; src[2] = pix_b;
    if (m_act[c] == 3) v = '0;
    else v = src[(m_act[c] + m_rot) % 3];
    if (m_inv[2-c]) v = ~v;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m_rot = 0; m_fcnt = 0; m_act = '{0, 1, 2}; m_inv = '0;
      pend = '0; exp_out = '0;
    end else begin
      if (!auto_rot) begin
        m_rot = 0; m_fcnt = 0;
      end else if (frame_start) begin
        if (m_fcnt == ROT - 1) begin
          m_fcnt = 0; m_rot = (m_rot + 1) % 3;
        end else m_fcnt++;
      end
      if (frame_start) begin
        m_act = '{int'(sel_r), int'(sel_g), int'(sel_b)};
`ifdef CMAP_INVERT_EN
        m_inv = inv_drv;
`endif
      end
      exp_out = pend;
      pend = {pix_valid, hsync_in, vsync_in, mdl_ch(0), mdl_ch(1), mdl_ch(2)};
    end
    #1;
  endtask

  task automatic set_pix(input int r, input int g, input int b, input logic v);
    pix_r = CH_W'(r); pix_g = CH_W'(g); pix_b = CH_W'(b); pix_valid = v;
  endtask

  task automatic set_sel(input int r, input int g, input int b);
    sel_r = 2'(r); sel_g = 2'(g); sel_b = 2'(b);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_pix($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 1'b1);
      hsync_in = 1'b1; vsync_in = 1'b1;
      step();
      total++;
      if (obs !== '0 || rot_state !== 2'd0) begin
        bad++; $display("FAIL reset_outputs got=%h rot=%0d want=0 rot=0", obs, rot_state);
      end
    end
    hsync_in = 1'b0; vsync_in = 1'b0;
  endtask

  task automatic test_identity();
    rst_n = 1'b1; auto_rot = 1'b0; set_sel(0, 1, 2);
    set_pix(3, 7, 12, 1'b1); frame_start = 1'b1;
    step();
    total++;
    if (obs !== exp_out) begin bad++; $display("FAIL identity_lat1 got=%h want=%h", obs, exp_out); end
    frame_start = 1'b0; set_pix(1, 1, 1, 1'b0);
    step();
    total++;
    if (obs !== {3'b100, 4'd3, 4'd7, 4'd12} || obs !== exp_out) begin
      bad++; $display("FAIL identity_pass got=%h want=%h", obs, {3'b100, 4'd3, 4'd7, 4'd12});
    end
  endtask

  task automatic test_midframe_sel();
    set_sel(2, 0, 3); set_pix(3, 7, 12, 1'b1); frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs !== exp_out || (i > 0 && obs !== {3'b100, 4'd3, 4'd7, 4'd12})) begin
        bad++; $display("FAIL midframe_hold got=%h want=%h", obs, exp_out);
      end
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0; set_pix(0, 0, 0, 1'b0);
    step();
    total++;
    if (obs !== {3'b100, 4'd12, 4'd3, 4'd0} || obs !== exp_out) begin
      bad++; $display("FAIL midframe_commit got=%h want=%h", obs, {3'b100, 4'd12, 4'd3, 4'd0});
    end
  endtask

  task automatic test_auto_rotate();
    int exp_seq[6] = '{0, 0, 1, 1, 2, 2};
    rst_n = 1'b0; step(); rst_n = 1'b1;
    set_sel(0, 1, 2); auto_rot = 1'b1;
    for (int f = 0; f < 6; f++) begin
      total++;
      if (rot_state !== 2'(exp_seq[f])) begin
        bad++; $display("FAIL rot_seq[%0d] got=%0d want=%0d", f, rot_state, exp_seq[f]);
      end
      frame_start = 1'b1; set_pix(3, 7, 12, 1'b1);
      step();
      frame_start = 1'b0; set_pix(5, 5, 5, 1'b0);
      step();
      total++;
      if (obs !== exp_out || (f == 1 && obs !== {3'b100, 4'd7, 4'd12, 4'd3})) begin
        bad++; $display("FAIL rot_map[%0d] got=%h want=%h", f, obs, exp_out);
      end
    end
    total++;
    if (rot_state !== 2'd0) begin bad++; $display("FAIL rot_wrap got=%0d want=0", rot_state); end
  endtask

  task automatic test_auto_rot_drop();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    set_sel(0, 1, 2); auto_rot = 1'b1;
    for (int f = 0; f < 5; f++) begin
      frame_start = 1'b1; step();
      frame_start = 1'b0; step();
    end
    total++;
    if (rot_state !== 2'd2 || dut.fcnt !== 4'd1) begin
      bad++; $display("FAIL drop_pre got rot=%0d fcnt=%0d want rot=2 fcnt=1", rot_state, dut.fcnt);
    end
    auto_rot = 1'b0; set_pix(3, 7, 12, 1'b1);
    step();
    total++;
    if (rot_state !== 2'd0 || dut.fcnt !== 4'd0) begin
      bad++; $display("FAIL drop_clear got rot=%0d fcnt=%0d want 0 0", rot_state, dut.fcnt);
    end
    set_pix(0, 0, 0, 1'b0);
    step();
    total++;
    if (obs !== {3'b100, 4'd3, 4'd7, 4'd12} || obs !== exp_out) begin
      bad++; $display("FAIL drop_plain got=%h want=%h", obs, {3'b100, 4'd3, 4'd7, 4'd12});
    end
  endtask

  task automatic test_reset_midframe();
    auto_rot = 1'b0; set_sel(3, 3, 3); set_pix(3, 7, 12, 1'b1); frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    total++;
    if (obs !== {3'b100, 12'h000} || obs !== exp_out) begin
      bad++; $display("FAIL zero_sel got=%h want=%h", obs, {3'b100, 12'h000});
    end
    rst_n = 1'b0;
    step();
    total++;
    if (obs !== '0) begin bad++; $display("FAIL rst_mid_flush got=%h want=0", obs); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs !== exp_out || (out_valid && obs[11:0] == 12'h000) ||
          (i > 0 && obs !== {3'b100, 4'd3, 4'd7, 4'd12})) begin
        bad++; $display("FAIL rst_mid_identity[%0d] got=%h want=%h", i, obs, exp_out);
      end
    end
  endtask

`ifdef CMAP_INVERT_EN
  task automatic test_invert();
    set_sel(3, 1, 2); inv_drv = 3'b100; set_pix(3, 7, 12, 1'b1); frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    total++;
    if (obs !== {3'b100, 4'hF, 4'd7, 4'd12} || obs !== exp_out) begin
      bad++; $display("FAIL invert got=%h want=%h", obs, {3'b100, 4'hF, 4'd7, 4'd12});
    end
    inv_drv = 3'b000;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n       = ($urandom_range(0, 99) != 0);
      frame_start = ($urandom_range(0, 5) == 0);
      auto_rot    = ($urandom_range(0, 9) != 0);
      set_sel($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      inv_drv     = 3'($urandom_range(0, 7));
      set_pix($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
              1'($urandom_range(0, 1)));
      hsync_in    = 1'($urandom_range(0, 1));
      vsync_in    = 1'($urandom_range(0, 1));
      step();
      total++;
      if (obs !== exp_out || rot_state !== 2'(m_rot)) begin
        bad++; $display("FAIL random[%0d] got=%h rot=%0d want=%h rot=%0d", i, obs, rot_state,
                        exp_out, m_rot);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_midframe_sel();
    test_auto_rotate();
    test_auto_rot_drop();
    test_reset_midframe();
`ifdef CMAP_INVERT_EN
    test_invert();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
